serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first. It is the subtraction counterpart to the NAND-built half adder. Its datapath is a single full-subtractor bit slice built only from the library's two-input NAND primitive, plus a borrow flip-flop. A small FSM with a start/busy/done handshake sequences the slice across the operand width. It serves arithmetic blocks that trade latency for gate count.

---
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor a - b, LSB first, using a NAND-only full-subtractor slice.
// Latency: WIDTH clock edges from the accepting edge to diff/borrow/done.
// Backpressure: start is only sampled while idle; requests while busy are dropped.
// Optional build macro SERIAL_SUB_SAT_EN: clamp diff to zero when the result underflows.

// Two-input NAND, the only gate the datapath slice is built from.
module serial_sub_nand2 (
    input  logic x,
    input  logic y,
    output logic z
);
    assign z = ~(x & y);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             bin;
    logic [CW-1:0]    cnt;

    // Slice internals: two half subtractors, each an XOR (4 NANDs) whose
    // third NAND output doubles as the inverted borrow (~(~x & y)).
    logic a0;
    logic b0;
    logic h1_n1, h1_n2, h1_n3, h1_d;
    logic h2_n1, h2_n2, h2_n3;
    logic d;
    logic bout;
    logic [WIDTH-1:0] d_final;

    assign a0 = a_sr[0];
    assign b0 = b_sr[0];

    // First half subtractor: a0 - b0
    serial_sub_nand2 u_h1_n1 (.x(a0),    .y(b0),    .z(h1_n1));
    serial_sub_nand2 u_h1_n2 (.x(a0),    .y(h1_n1), .z(h1_n2));
    serial_sub_nand2 u_h1_n3 (.x(b0),    .y(h1_n1), .z(h1_n3));
    serial_sub_nand2 u_h1_d  (.x(h1_n2), .y(h1_n3), .z(h1_d));

    // Second half subtractor: (a0 ^ b0) - bin
    serial_sub_nand2 u_h2_n1 (.x(h1_d),  .y(bin),   .z(h2_n1));
    serial_sub_nand2 u_h2_n2 (.x(h1_d),  .y(h2_n1), .z(h2_n2));
    serial_sub_nand2 u_h2_n3 (.x(bin),   .y(h2_n1), .z(h2_n3));
    serial_sub_nand2 u_h2_d  (.x(h2_n2), .y(h2_n3), .z(d));

    // OR of the two borrows in NAND form, fed directly by the inverted borrows
    serial_sub_nand2 u_bout  (.x(h1_n3), .y(h2_n3), .z(bout));

    assign d_final = {d, d_sr[WIDTH-1:1]};
    assign busy    = (state == RUN);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept a request when idle, finish after the last bit
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/result shift registers, borrow chain, bit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            bin    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_sr <= a;
                b_sr <= b;
                d_sr <= '0;
                bin  <= 1'b0;
                cnt  <= '0;
            end else if (busy) begin
                a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                d_sr <= d_final;
                bin  <= bout;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    borrow <= bout;
`ifdef SERIAL_SUB_SAT_EN
                    diff   <= bout ? '0 : d_final;
`else
                    diff   <= d_final;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed corners plus random operands.
// Expected results come from plain arithmetic on the operands.
// Checks handshake timing, ignored starts, reset abort and back-to-back throughput.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int tests;
    int fails;

    // Model of the currently held result
    logic [W-1:0] exp_diff;
    logic         exp_borrow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: unsigned a - b, wrapped to W bits, borrow when a < b
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv);
        int unsigned r;
        r = (int'(av) - int'(bv)) & ((1 << W) - 1);
        exp_borrow = (av < bv);
        exp_diff   = r[W-1:0];
`ifdef SERIAL_SUB_SAT_EN
        if (exp_borrow) exp_diff = '0;
`endif
    endtask

    // One operation; inject_at >= 0 drives a second (ignored) start mid-run
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int inject_at);
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_run", {31'd0, done}, 32'd0);
            check("diff_hold", {24'd0, diff}, {24'd0, exp_diff});
            if (k == inject_at) begin
                start = 1'b1;
                a = 8'h00;
                b = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        model(av, bv);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("diff", {24'd0, diff}, {24'd0, exp_diff});
        check("borrow", {31'd0, borrow}, {31'd0, exp_borrow});
        @(negedge clk);
        check("done_single", {31'd0, done}, 32'd0);
        check("idle_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_diff = '0;
        exp_borrow = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_op(8'h5A, 8'h23, -1);
        do_op(8'h10, 8'h20, -1);
        do_op(8'hFF, 8'hFF, -1);
        do_op(8'h00, 8'h01, -1);
        do_op(8'hFF, 8'h00, -1);
        // Second start at T+3 is ignored
        do_op(8'h5A, 8'h23, 2);

        // Reset mid-run aborts the operation
        @(negedge clk);
        start = 1'b1;
        a = 8'h5A;
        b = 8'h23;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_diff = '0;
        exp_borrow = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_diff", {24'd0, diff}, 32'd0);
        check("abort_borrow", {31'd0, borrow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        do_op(8'h5A, 8'h23, -1);

        // Random operands
        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), -1);
        end

        // Start held high: one result every W+1 cycles
        @(negedge clk);
        start = 1'b1;
        a = 8'h80;
        b = 8'h01;
        model(8'h80, 8'h01);
        @(posedge clk);
        for (int k = 0; k < 3 * (W + 1); k++) begin
            @(negedge clk);
            check("stream_done", {31'd0, done}, {31'd0, ((k % (W + 1)) == W)});
            if (done) begin
                check("stream_diff", {24'd0, diff}, {24'd0, exp_diff});
                check("stream_borrow", {31'd0, borrow}, {31'd0, exp_borrow});
            end
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
